// File: rtl/prim_fifo_unpack.sv
// prim_fifo_unpack
//
// Single-clock width downsizer for the read side of the asynchronous FIFO.
// It takes one InW-bit word from the FIFO read port through a valid/ready
// handshake and emits it as Ratio = InW/OutW narrower beats. A last-beat
// marker goes with the beats to a serial consumer. With ready_i held high it
// sustains one beat per cycle, and the next word loads in the same cycle the
// last beat leaves, so there are no bubbles between words.
//
// Build option:
//   PRIM_FIFO_UNPACK_MSB_FIRST_EN - when defined, beats leave MSB-first;
//                                   otherwise (default) LSB-first.
//
// Ports:
//   clk_i    in   1     clock, all state on the rising edge
//   rst_ni   in   1     asynchronous active-low reset
//   valid_i  in   1     input word valid (FIFO rvalid_o)
//   ready_o  out  1     input word accepted (FIFO rready_i)
//   data_i   in   InW   input word (FIFO rdata_o)
//   flush_i  in   1     synchronous discard of the held word
//   valid_o  out  1     output beat valid
//   ready_i  in   1     consumer accepts the beat
//   data_o   out  OutW  current beat
//   last_o   out  1     current beat is the final beat of its word
//   busy_o   out  1     a word is held
//
// State | meaning
// ------+--------------------------------------------------------
// EMPTY | no word held; ready_o follows !flush_i
// HOLD  | word_q held; beat cnt_q is presented on data_o

module prim_fifo_unpack #(
  parameter int unsigned InW  = 32,
  parameter int unsigned OutW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [InW-1:0]  data_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [OutW-1:0] data_o,
  output logic            last_o,
  output logic            busy_o
);

  localparam int unsigned Ratio = InW / OutW;
  localparam int unsigned CntW  = $clog2(Ratio);
  localparam logic [CntW-1:0] LastIdx = CntW'(Ratio - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e                     state_q;
  logic [CntW-1:0]            cnt_q;
  logic [InW-1:0]             word_q;
  logic                       valid_q;
  logic                       beat_fire;
  logic                       load;
  logic [CntW-1:0]            beat_sel;
  logic [Ratio-1:0][OutW-1:0] word_beats;

  assign valid_q = (state_q == HOLD);

  assign valid_o   = valid_q;
  assign busy_o    = valid_q;
  assign last_o    = valid_q & (cnt_q == LastIdx);
  assign beat_fire = valid_o & ready_i;

  // The path from ready_i to ready_o is combinational on purpose. It lets the
  // next word load in the same cycle the last beat fires, which keeps the
  // output at full rate.
  assign ready_o = !flush_i & (!valid_q | (beat_fire & last_o));
  assign load    = valid_i & ready_o;

`ifdef PRIM_FIFO_UNPACK_MSB_FIRST_EN
  assign beat_sel = LastIdx - cnt_q;
`else
  assign beat_sel = cnt_q;
`endif

  assign word_beats = word_q;
  assign data_o     = word_beats[beat_sel];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else if (flush_i) begin
      // A beat taken during the flush cycle still counts for the consumer,
      // but the rest of the word is dropped.
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else if (load) begin
      state_q <= HOLD;
      cnt_q   <= '0;
    end else if (beat_fire && last_o) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else if (beat_fire) begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // The data holding register has no reset. Its contents matter only while
  // in HOLD, and reset forces EMPTY.
  always_ff @(posedge clk_i) begin
    if (load) begin
      word_q <= data_i;
    end
  end

endmodule
